// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of the memory arbiter.
// slave: the arbiter's view. master: the requesters and the RAM.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              rdy;
  logic              jump_wrong;

  logic              if_read_signal;
  logic [ADDR_W-1:0] if_addr;
  logic              if_success;
  logic [31:0]       if_data;

  logic              lsb_read_signal;
  logic              lsb_write_signal;
  logic [1:0]        lsb_len;
  logic              lsb_signed;
  logic [ADDR_W-1:0] lsb_addr;
  logic [31:0]       lsb_wdata;
  logic              mem_load_success;
  logic              mem_store_success;
  logic [31:0]       from_mem_data;

  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport slave (
    input  rdy, jump_wrong,
    input  if_read_signal, if_addr,
    output if_success, if_data,
    input  lsb_read_signal, lsb_write_signal, lsb_len, lsb_signed, lsb_addr, lsb_wdata,
    output mem_load_success, mem_store_success, from_mem_data,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output rdy, jump_wrong,
    output if_read_signal, if_addr,
    input  if_success, if_data,
    output lsb_read_signal, lsb_write_signal, lsb_len, lsb_signed, lsb_addr, lsb_wdata,
    input  mem_load_success, mem_store_success, from_mem_data,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter: fetch vs. load/store, serialising 1/2/4-byte accesses
// into single-byte RAM cycles with load extension and one-cycle completion pulses.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter logic [1:0]  IO_HI  = 2'b11
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIfRd, StLsRd, StLsWr} state_e;

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic [2:0]        nbytes_q;
  logic [1:0]        len_q;
  logic              sign_q;
  logic              last_lsb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [31:0]       wdata_q;
  logic [31:0]       if_data_q;
  logic [31:0]       ld_data_q;
  logic [23:0]       rbuf_q;
  logic [7:0]        dout_q;
  logic              wr_q;
  logic              if_ok_q;
  logic              ld_ok_q;
  logic              st_ok_q;

  logic              grant_if;
  logic              grant_rd;
  logic              grant_wr;
  logic              io_stall_new;
  logic              io_stall;
  logic [ADDR_W-1:0] next_a;
  logic [31:0]       rd_word;
  logic [31:0]       ld_ext;
  logic [7:0]        wr_byte;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Fetch wins over a pending LSB request right after an LSB completion.
  always_comb begin
    grant_if = 1'b0;
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (state_q == StIdle) begin
      if (last_lsb_q && bus.if_read_signal && !bus.jump_wrong) begin
        grant_if = 1'b1;
      end else if (bus.lsb_write_signal) begin
        grant_wr = 1'b1;
      end else if (bus.lsb_read_signal && !bus.jump_wrong) begin
        grant_rd = 1'b1;
      end else if (bus.if_read_signal && !bus.jump_wrong) begin
        grant_if = 1'b1;
      end
    end
  end

  assign io_stall_new = (bus.lsb_addr[17:16] == IO_HI) && bus.io_buffer_full;
  assign io_stall     = (addr_q[17:16] == IO_HI) && bus.io_buffer_full;
  assign next_a       = addr_q + ADDR_W'(cnt_q);

  // Final read byte arrives on mem_din in the completing cycle; merge it into the buffer.
  always_comb begin
    rd_word = {8'h00, rbuf_q};
    case (cnt_q)
      3'd1:    rd_word[7:0]   = bus.mem_din;
      3'd2:    rd_word[15:8]  = bus.mem_din;
      3'd3:    rd_word[23:16] = bus.mem_din;
      default: rd_word[31:24] = bus.mem_din;
    endcase
    case (len_q)
      2'd0:    ld_ext = {{24{sign_q & rd_word[7]}}, rd_word[7:0]};
      2'd1:    ld_ext = {{16{sign_q & rd_word[15]}}, rd_word[15:0]};
      default: ld_ext = rd_word;
    endcase
    case (cnt_q[1:0])
      2'd0:    wr_byte = wdata_q[7:0];
      2'd1:    wr_byte = wdata_q[15:8];
      2'd2:    wr_byte = wdata_q[23:16];
      default: wr_byte = wdata_q[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      nbytes_q   <= 3'd0;
      len_q      <= 2'd0;
      sign_q     <= 1'b0;
      last_lsb_q <= 1'b0;
      addr_q     <= '0;
      mem_a_q    <= '0;
      wdata_q    <= 32'h0;
      if_data_q  <= 32'h0;
      ld_data_q  <= 32'h0;
      rbuf_q     <= 24'h0;
      dout_q     <= 8'h00;
      wr_q       <= 1'b0;
      if_ok_q    <= 1'b0;
      ld_ok_q    <= 1'b0;
      st_ok_q    <= 1'b0;
    end else if (bus.rdy) begin
      if_ok_q <= 1'b0;
      ld_ok_q <= 1'b0;
      st_ok_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_if) begin
            state_q  <= StIfRd;
            addr_q   <= bus.if_addr;
            mem_a_q  <= bus.if_addr;
            nbytes_q <= 3'd4;
            len_q    <= 2'd2;
            sign_q   <= 1'b0;
            rbuf_q   <= 24'h0;
            cnt_q    <= 3'd1;
          end else if (grant_rd) begin
            state_q  <= StLsRd;
            addr_q   <= bus.lsb_addr;
            mem_a_q  <= bus.lsb_addr;
            nbytes_q <= len_bytes(bus.lsb_len);
            len_q    <= bus.lsb_len;
            sign_q   <= bus.lsb_signed;
            rbuf_q   <= 24'h0;
            cnt_q    <= 3'd1;
          end else if (grant_wr) begin
            state_q  <= StLsWr;
            addr_q   <= bus.lsb_addr;
            mem_a_q  <= bus.lsb_addr;
            nbytes_q <= len_bytes(bus.lsb_len);
            wdata_q  <= bus.lsb_wdata;
            // cnt counts bytes already issued; a stalled grant issues nothing yet.
            if (io_stall_new) begin
              wr_q  <= 1'b0;
              cnt_q <= 3'd0;
            end else begin
              wr_q   <= 1'b1;
              dout_q <= bus.lsb_wdata[7:0];
              cnt_q  <= 3'd1;
            end
          end
        end
        StIfRd, StLsRd: begin
          if (bus.jump_wrong) begin
            state_q <= StIdle;
            mem_a_q <= '0;
            cnt_q   <= 3'd0;
          end else if (cnt_q < nbytes_q) begin
            case (cnt_q)
              3'd1:    rbuf_q[7:0]   <= bus.mem_din;
              3'd2:    rbuf_q[15:8]  <= bus.mem_din;
              default: rbuf_q[23:16] <= bus.mem_din;
            endcase
            mem_a_q <= next_a;
            cnt_q   <= cnt_q + 3'd1;
          end else begin
            if (state_q == StIfRd) begin
              if_data_q  <= rd_word;
              if_ok_q    <= 1'b1;
              last_lsb_q <= 1'b0;
            end else begin
              ld_data_q  <= ld_ext;
              ld_ok_q    <= 1'b1;
              last_lsb_q <= 1'b1;
            end
            state_q <= StIdle;
            mem_a_q <= '0;
            cnt_q   <= 3'd0;
          end
        end
        StLsWr: begin
          if (cnt_q == nbytes_q) begin
            wr_q       <= 1'b0;
            st_ok_q    <= 1'b1;
            last_lsb_q <= 1'b1;
            state_q    <= StIdle;
            mem_a_q    <= '0;
            cnt_q      <= 3'd0;
          end else if (io_stall) begin
            wr_q <= 1'b0;
          end else begin
            mem_a_q <= next_a;
            dout_q  <= wr_byte;
            wr_q    <= 1'b1;
            cnt_q   <= cnt_q + 3'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.if_success        = if_ok_q;
  assign bus.if_data           = if_data_q;
  assign bus.mem_load_success  = ld_ok_q;
  assign bus.mem_store_success = st_ok_q;
  assign bus.from_mem_data     = ld_data_q;
  assign bus.mem_a             = mem_a_q;
  assign bus.mem_dout          = dout_q;
  assign bus.mem_wr            = wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand-written corner sequences,
// with expected read data and expected RAM writes kept in scoreboard queues.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Combinational RAM read: byte for mem_a is sampled by the DUT on the following edge.
  logic [7:0] ram [0:1023];
  assign bus.mem_din = ram[bus.mem_a[9:0]];

  logic [39:0] obs_q[$];
  logic [39:0] exp_wr_q[$];
  logic [31:0] if_q[$];
  logic [31:0] ld_q[$];
  int total = 0;
  int bad   = 0;

  always @(posedge clk) begin
    if (bus.rdy === 1'b1 && bus.mem_wr === 1'b1) obs_q.push_back({bus.mem_a, bus.mem_dout});
  end

  typedef struct {
    int          kind;   // 0 fetch, 1 load, 2 store
    logic [31:0] addr;
    logic [1:0]  len;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          edges;  // grant edge through the edge that raises the pulse
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  task automatic push_writes(input logic [31:0] addr, input logic [1:0] len,
                             input logic [31:0] wdata);
    for (int k = 0; k < nbytes(len); k++) begin
      exp_wr_q.push_back({addr + 32'(k), 8'(wdata >> (8 * k))});
    end
  endtask

  task automatic check_writes(input string name);
    logic [39:0] o;
    logic [39:0] e;
    check({name, " write count"}, 64'(obs_q.size()), 64'(exp_wr_q.size()));
    while (obs_q.size() > 0 && exp_wr_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_wr_q.pop_front();
      check({name, " write"}, 64'(o), 64'(e));
      if (o[25:24] != 2'b11) ram[o[17:8]] = o[7:0];
    end
    obs_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic wait_pulse(input int kind, input int bound, output int edges,
                            output logic [31:0] data);
    bit got = 0;
    edges = 0;
    data  = 32'h0;
    for (int i = 0; i < bound && !got; i++) begin
      step();
      edges++;
      if (kind == 0 && bus.if_success) begin got = 1; data = bus.if_data; end
      if (kind == 1 && bus.mem_load_success) begin got = 1; data = bus.from_mem_data; end
      if (kind == 2 && bus.mem_store_success) got = 1;
    end
    if (!got) edges = -1;
  endtask

  task automatic pop_check(input string name, input int kind, input logic [31:0] data);
    logic [31:0] e;
    if (kind == 0) begin
      if (if_q.size() == 0) begin check({name, " unexpected fetch"}, 64'(1), 64'(0)); return; end
      e = if_q.pop_front();
    end else begin
      if (ld_q.size() == 0) begin check({name, " unexpected load"}, 64'(1), 64'(0)); return; end
      e = ld_q.pop_front();
    end
    check({name, " data"}, 64'(data), 64'(e));
  endtask

  task automatic add(input int kind, input logic [31:0] addr, input logic [1:0] len,
                     input logic sgn, input logic [31:0] wdata, input logic [31:0] exp,
                     input int edges);
    vec_t v;
    v.kind = kind; v.addr = addr; v.len = len; v.sgn = sgn;
    v.wdata = wdata; v.exp = exp; v.edges = edges;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          e;
    logic [31:0] d;
    string       nm;
    nm = $sformatf("vec%0d", idx);
    case (v.kind)
      0: begin
        if_q.push_back(v.exp);
        bus.if_addr = v.addr;
        bus.if_read_signal = 1'b1;
        wait_pulse(0, 20, e, d);
        bus.if_read_signal = 1'b0;
      end
      1: begin
        ld_q.push_back(v.exp);
        bus.lsb_addr = v.addr; bus.lsb_len = v.len; bus.lsb_signed = v.sgn;
        bus.lsb_read_signal = 1'b1;
        wait_pulse(1, 20, e, d);
        bus.lsb_read_signal = 1'b0;
      end
      default: begin
        push_writes(v.addr, v.len, v.wdata);
        bus.lsb_addr = v.addr; bus.lsb_len = v.len; bus.lsb_wdata = v.wdata;
        bus.lsb_write_signal = 1'b1;
        wait_pulse(2, 20, e, d);
        bus.lsb_write_signal = 1'b0;
      end
    endcase
    check({nm, " latency"}, 64'(e), 64'(v.edges));
    if (v.kind < 2) pop_check(nm, v.kind, d);
    else check_writes(nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          e;
    int          e2;
    int          cnt;
    int          code;
    int          order[$];
    logic [31:0] d;
    logic [31:0] held_a;

    for (int i = 0; i < 1024; i++) ram[i] = 8'(i * 7 + 3);
    ram[10'h000] = 8'h13; ram[10'h001] = 8'h05; ram[10'h002] = 8'h00; ram[10'h003] = 8'h00;
    ram[10'h020] = 8'h80; ram[10'h021] = 8'h7F;
    ram[10'h040] = 8'h34; ram[10'h041] = 8'hF2;
    ram[10'h080] = 8'h78; ram[10'h081] = 8'h56; ram[10'h082] = 8'h34; ram[10'h083] = 8'h12;
    ram[10'h084] = 8'h9A;
    ram[10'h3FE] = 8'hEF; ram[10'h3FF] = 8'hBE;

    rst = 1'b1;
    bus.rdy = 1'b0; bus.jump_wrong = 1'b0; bus.io_buffer_full = 1'b0;
    bus.if_read_signal = 1'b0; bus.if_addr = 32'h0;
    bus.lsb_read_signal = 1'b0; bus.lsb_write_signal = 1'b0;
    bus.lsb_len = 2'd0; bus.lsb_signed = 1'b0; bus.lsb_addr = 32'h0; bus.lsb_wdata = 32'h0;

    // Reset applies even with rdy low.
    repeat (3) step();
    check("reset mem_wr", 64'(bus.mem_wr), 64'(0));
    check("reset mem_a", 64'(bus.mem_a), 64'(0));
    check("reset mem_dout", 64'(bus.mem_dout), 64'(0));
    check("reset pulses", 64'({bus.if_success, bus.mem_load_success, bus.mem_store_success}),
          64'(0));
    check("reset data", 64'({bus.if_data, bus.from_mem_data}), 64'(0));
    rst = 1'b0;
    bus.rdy = 1'b1;
    step();

    add(0, 32'h0000_1000, 2'd2, 1'b0, 32'h0, 32'h0000_0513, 5);
    add(1, 32'h0000_0020, 2'd0, 1'b1, 32'h0, 32'hFFFF_FF80, 2);
    add(1, 32'h0000_0020, 2'd0, 1'b0, 32'h0, 32'h0000_0080, 2);
    add(1, 32'h0000_0021, 2'd0, 1'b1, 32'h0, 32'h0000_007F, 2);
    add(1, 32'h0000_0040, 2'd1, 1'b1, 32'h0, 32'hFFFF_F234, 3);
    add(1, 32'h0000_0040, 2'd1, 1'b0, 32'h0, 32'h0000_F234, 3);
    add(1, 32'h0000_0080, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 5);
    add(1, 32'h0000_0081, 2'd2, 1'b1, 32'h0, 32'h9A12_3456, 5);
    add(1, 32'h0000_0080, 2'd3, 1'b1, 32'h0, 32'h1234_5678, 5);
    add(1, 32'hFFFF_FFFE, 2'd2, 1'b0, 32'h0, 32'h0513_BEEF, 5);
    add(2, 32'h0000_0200, 2'd0, 1'b0, 32'hAABB_CCDD, 32'h0, 2);
    add(2, 32'h0000_0210, 2'd1, 1'b0, 32'h1122_3344, 32'h0, 3);
    add(2, 32'h0000_0220, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0, 5);
    add(1, 32'h0000_0220, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 5);
    add(1, 32'h0000_0211, 2'd0, 1'b0, 32'h0, 32'h0000_0033, 2);
    add(1, 32'h0000_0223, 2'd0, 1'b1, 32'h0, 32'hFFFF_FFCA, 2);
    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // IO store stalled for three edges after the second byte is issued.
    push_writes(32'h0003_0000, 2'd2, 32'h4142_4344);
    bus.lsb_addr = 32'h0003_0000; bus.lsb_len = 2'd2; bus.lsb_wdata = 32'h4142_4344;
    bus.lsb_write_signal = 1'b1;
    step();
    step();
    bus.io_buffer_full = 1'b1;
    step();
    step();
    check("io stall mem_wr", 64'(bus.mem_wr), 64'(0));
    step();
    bus.io_buffer_full = 1'b0;
    wait_pulse(2, 20, e, d);
    bus.lsb_write_signal = 1'b0;
    check("io stall latency", 64'(e < 0 ? -1 : e + 5), 64'(8));
    check_writes("io stall");

    // Flush while the third byte of a word load is on the bus.
    bus.lsb_addr = 32'h0000_0080; bus.lsb_len = 2'd2; bus.lsb_signed = 1'b0;
    bus.lsb_read_signal = 1'b1;
    step();
    step();
    step();
    check("jw load mem_a", 64'(bus.mem_a), 64'(32'h82));
    bus.jump_wrong = 1'b1;
    step();
    bus.jump_wrong = 1'b0;
    bus.lsb_read_signal = 1'b0;
    check("jw load abort mem_a", 64'(bus.mem_a), 64'(0));
    cnt = 0;
    repeat (8) begin
      step();
      if (bus.mem_load_success) cnt++;
    end
    check("jw load no pulse", 64'(cnt), 64'(0));

    // No read grant on a flush edge; the held request is granted afterwards.
    ld_q.push_back(32'hFFFF_FF80);
    bus.lsb_addr = 32'h0000_0020; bus.lsb_len = 2'd0; bus.lsb_signed = 1'b1;
    bus.lsb_read_signal = 1'b1;
    bus.jump_wrong = 1'b1;
    step();
    bus.jump_wrong = 1'b0;
    check("jw no grant", 64'(bus.mem_a), 64'(0));
    wait_pulse(1, 20, e, d);
    bus.lsb_read_signal = 1'b0;
    check("jw no grant latency", 64'(e), 64'(2));
    pop_check("jw no grant", 1, d);

    // A flush does not cancel a store in progress.
    push_writes(32'h0000_0240, 2'd1, 32'h0000_5566);
    bus.lsb_addr = 32'h0000_0240; bus.lsb_len = 2'd1; bus.lsb_wdata = 32'h0000_5566;
    bus.lsb_write_signal = 1'b1;
    step();
    bus.jump_wrong = 1'b1;
    step();
    bus.jump_wrong = 1'b0;
    wait_pulse(2, 20, e, d);
    bus.lsb_write_signal = 1'b0;
    check("jw store latency", 64'(e < 0 ? -1 : e + 2), 64'(3));
    check_writes("jw store");

    // rdy low for three edges in the middle of a word load.
    ld_q.push_back(32'h1234_5678);
    bus.lsb_addr = 32'h0000_0080; bus.lsb_len = 2'd2; bus.lsb_signed = 1'b0;
    bus.lsb_read_signal = 1'b1;
    step();
    step();
    held_a = bus.mem_a;
    bus.rdy = 1'b0;
    cnt = 0;
    repeat (3) begin
      step();
      if (bus.mem_load_success) cnt++;
    end
    check("freeze mem_a", 64'(bus.mem_a), 64'(held_a));
    check("freeze no pulse", 64'(cnt), 64'(0));
    bus.rdy = 1'b1;
    wait_pulse(1, 20, e, d);
    bus.lsb_read_signal = 1'b0;
    check("freeze latency", 64'(e < 0 ? -1 : e + 5), 64'(8));
    pop_check("freeze", 1, d);

    // Reset in the middle of a word store: the two bytes already on the bus land.
    push_writes(32'h0000_0300, 2'd1, 32'h0102_0304);
    bus.lsb_addr = 32'h0000_0300; bus.lsb_len = 2'd2; bus.lsb_wdata = 32'h0102_0304;
    bus.lsb_write_signal = 1'b1;
    step();
    step();
    rst = 1'b1;
    bus.lsb_write_signal = 1'b0;
    step();
    rst = 1'b0;
    check("rst mid store outputs",
          64'({bus.mem_wr, bus.mem_a, bus.mem_dout, bus.mem_store_success}), 64'(0));
    cnt = 0;
    repeat (5) begin
      step();
      if (bus.mem_store_success) cnt++;
    end
    check("rst mid store no pulse", 64'(cnt), 64'(0));
    check_writes("rst mid store");

    // Fetch and word load held together from a fresh reset: load, fetch, load.
    ld_q.push_back(32'h1234_5678);
    ld_q.push_back(32'h1234_5678);
    if_q.push_back(32'h0000_0513);
    bus.lsb_addr = 32'h0000_0080; bus.lsb_len = 2'd2; bus.lsb_signed = 1'b0;
    bus.if_addr = 32'h0000_1000;
    bus.lsb_read_signal = 1'b1;
    bus.if_read_signal = 1'b1;
    for (int i = 0; i < 60 && order.size() < 3; i++) begin
      step();
      if (bus.mem_load_success) begin order.push_back(1); pop_check("arb", 1, bus.from_mem_data); end
      if (bus.if_success) begin order.push_back(0); pop_check("arb", 0, bus.if_data); end
      if (order.size() == 3) begin
        bus.lsb_read_signal = 1'b0;
        bus.if_read_signal = 1'b0;
      end
    end
    bus.lsb_read_signal = 1'b0;
    bus.if_read_signal = 1'b0;
    code = 0;
    foreach (order[i]) code = code * 10 + order[i] + 1;
    check("arb order", 64'(code), 64'(212));

    repeat (4) step();
    check("leftover reads", 64'(if_q.size() + ld_q.size()), 64'(0));
    check("leftover writes", 64'(obs_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
